// File: rtl/loss_pkg.sv
// Shared types, default widths and saturation helper for the loss-stage units.
package loss_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC_W = 8;
  localparam int unsigned DEF_ACC_W  = 40;
  localparam int unsigned DEF_CNT_W  = 16;

  // Width of the intermediate handed to sat_to_data; must cover the scale product.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    SCALE
  } loss_fwd_state_t;

  // Clamp a wide signed value into the signed range of a w-bit result.
  function automatic logic signed [SAT_W-1:0] sat_to_data(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/loss_parent_fwd_sq_err_pipe.sv
// Two-stage registered pipe: stage 1 holds exact H-Y, stage 2 holds its square.
module sq_err_pipe #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     h_i,
  input  logic [DATA_W-1:0]     y_i,
  input  logic                  valid_i,
  output logic                  diff_valid_o,
  output logic [2*DATA_W+1:0]   sq_o,
  output logic                  sq_valid_o
);

  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned SQ_W   = 2 * DATA_W + 2;

  logic signed [DIFF_W-1:0] diff_d, diff_q;
  logic signed [SQ_W-1:0]   sq_d;
  logic [SQ_W-1:0]          sq_q;
  logic                     diff_valid_q, sq_valid_q;

  // One extra bit keeps the difference exact for any pair of inputs.
  always_comb begin
    diff_d = DIFF_W'($signed(h_i)) - DIFF_W'($signed(y_i));
    sq_d   = SQ_W'(diff_q) * SQ_W'(diff_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
      sq_q         <= '0;
      sq_valid_q   <= 1'b0;
    end else begin
      diff_valid_q <= valid_i;
      sq_valid_q   <= diff_valid_q;
      if (valid_i) begin
        diff_q <= diff_d;
      end
      if (diff_valid_q) begin
        sq_q <= sq_d;
      end
    end
  end

  assign diff_valid_o = diff_valid_q;
  assign sq_o         = sq_q;
  assign sq_valid_o   = sq_valid_q;

endmodule

// File: rtl/loss_parent_fwd.sv
// Forward MSE loss: accumulates (H-Y)^2 over a batch and scales once by 1/N.
// Optional sticky saturation flag overflow_out when LOSS_PARENT_OVF_FLAG_EN is defined.
module loss_parent_fwd #(
  parameter int unsigned DATA_W = loss_pkg::DEF_DATA_W,
  parameter int unsigned FRAC_W = loss_pkg::DEF_FRAC_W,
  parameter int unsigned ACC_W  = loss_pkg::DEF_ACC_W,
  parameter int unsigned CNT_W  = loss_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] H_in,
  input  logic [DATA_W-1:0] Y_in,
  input  logic              valid_in,
  input  logic [CNT_W-1:0]  batch_size_in,
  input  logic [DATA_W-1:0] inv_batch_size_in,
  output logic              ready_out,
  output logic              busy_out,
  output logic [DATA_W-1:0] loss_out,
  output logic              loss_valid
`ifdef LOSS_PARENT_OVF_FLAG_EN
  ,
  output logic              overflow_out
`endif
);

  import loss_pkg::*;

  localparam int unsigned SQ_W   = 2 * DATA_W + 2;
  localparam int unsigned PROD_W = ACC_W + 1 + DATA_W;

  loss_fwd_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] loss_q, loss_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              loss_valid_q, loss_valid_d;

  logic              accept_c;
  logic              start_c;
  logic [CNT_W-1:0]  n_eff_c;
  logic              diff_valid;
  logic              sq_valid;
  logic [SQ_W-1:0]   sq;
  logic [ACC_W:0]    acc_sum_c;
  logic              acc_sat_c;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod_sh_c;
  logic signed [SAT_W-1:0]  scaled_c;
  logic signed [SAT_W-1:0]  scaled_sat_c;

  assign accept_c = valid_in & ready_q;
  assign n_eff_c  = (batch_size_in == '0) ? CNT_W'(1) : batch_size_in;

  sq_err_pipe #(
    .DATA_W (DATA_W)
  ) u_sq_err_pipe (
    .clk          (clk),
    .rst          (rst),
    .h_i          (H_in),
    .y_i          (Y_in),
    .valid_i      (accept_c),
    .diff_valid_o (diff_valid),
    .sq_o         (sq),
    .sq_valid_o   (sq_valid)
  );

  // Stage 3: saturating accumulate of the squared error.
  always_comb begin
    acc_sum_c = {1'b0, acc_q} + (ACC_W + 1)'(sq);
    acc_sat_c = acc_sum_c[ACC_W];
    acc_d     = acc_q;
    if (start_c) begin
      acc_d = '0;
    end else if (sq_valid) begin
      acc_d = acc_sat_c ? '1 : acc_sum_c[ACC_W-1:0];
    end
  end

  // Scale by 1/N; the arithmetic shift floors toward negative infinity.
  always_comb begin
    prod_c       = PROD_W'($signed({1'b0, acc_q})) * PROD_W'($signed(inv_batch_size_in));
    prod_sh_c    = prod_c >>> (2 * FRAC_W);
    scaled_c     = SAT_W'(prod_sh_c);
    scaled_sat_c = sat_to_data(scaled_c, DATA_W);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_d       = loss_q;
    loss_valid_d = 1'b0;
    start_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          start_c = 1'b1;
          cnt_d   = n_eff_c - CNT_W'(1);
          state_d = (n_eff_c == CNT_W'(1)) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // Stage 2 still holds the last square when stage 1 empties; it lands this edge.
      DRAIN: begin
        if (!diff_valid) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        loss_d       = DATA_W'(scaled_sat_c);
        loss_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == ACCUM);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      loss_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      loss_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      loss_q       <= loss_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      loss_valid_q <= loss_valid_d;
    end
  end

  assign ready_out  = ready_q;
  assign busy_out   = busy_q;
  assign loss_out   = loss_q;
  assign loss_valid = loss_valid_q;

`ifdef LOSS_PARENT_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic scale_sat_c;

  assign scale_sat_c = (scaled_sat_c != scaled_c);

  // Sticky per batch; cleared by the first accepted sample of the next batch.
  always_comb begin
    ovf_d = ovf_q;
    if (start_c) begin
      ovf_d = 1'b0;
    end else begin
      if (sq_valid && acc_sat_c) begin
        ovf_d = 1'b1;
      end
      if ((state_q == SCALE) && scale_sat_c) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_out = ovf_q;
`endif

endmodule

// File: tb/tb_loss_parent_fwd.sv
// Self-checking bench for loss_parent_fwd: directed plan plus random stimulus against a batch-level model.
module tb_loss_parent_fwd;

  localparam longint ACC_MAX = (longint'(1) << 40) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] H_in = '0;
  logic [15:0] Y_in = '0;
  logic        valid_in = 1'b0;
  logic [15:0] batch_size_in = '0;
  logic [15:0] inv_batch_size_in = '0;
  logic        ready_out;
  logic        busy_out;
  logic [15:0] loss_out;
  logic        loss_valid;
`ifdef LOSS_PARENT_OVF_FLAG_EN
  logic        overflow_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: expected outputs for the current cycle plus batch bookkeeping.
  bit          m_ready, m_busy, m_lv, m_in_batch, m_acc_sat, m_ovf;
  int          m_rem, m_drain;
  longint      m_acc;
  logic [15:0] m_loss;

  logic [15:0] got_loss;
  int          pulses;

  always #5 clk = ~clk;

  loss_parent_fwd dut (
    .clk               (clk),
    .rst               (rst),
    .H_in              (H_in),
    .Y_in              (Y_in),
    .valid_in          (valid_in),
    .batch_size_in     (batch_size_in),
    .inv_batch_size_in (inv_batch_size_in),
    .ready_out         (ready_out),
    .busy_out          (busy_out),
    .loss_out          (loss_out),
    .loss_valid        (loss_valid)
`ifdef LOSS_PARENT_OVF_FLAG_EN
    ,
    .overflow_out      (overflow_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b1; m_busy = 1'b0; m_lv = 1'b0; m_loss = '0;
    m_in_batch = 1'b0; m_acc_sat = 1'b0; m_ovf = 1'b0;
    m_rem = 0; m_drain = 0; m_acc = 0;
  endtask

  // loss = floor(acc * inv / 2^16), clamped to signed 16 bits.
  function automatic longint scale_model(input longint acc, input logic [15:0] inv, output bit sat);
    longint p;
    p = (acc * longint'($signed(inv))) >>> 16;
    sat = 1'b0;
    if (p > 32767) begin p = 32767; sat = 1'b1; end
    if (p < -32768) begin p = -32768; sat = 1'b1; end
    return p;
  endfunction

  // Check this cycle's outputs, apply inputs, advance the model, move to the next cycle.
  task automatic cyc(input logic v, input logic [15:0] h, input logic [15:0] y,
                     input logic [15:0] n, input logic [15:0] inv);
    bit     acc_ok, sat;
    longint d, q;
    check("ready_out", ready_out, m_ready);
    check("busy_out", busy_out, m_busy);
    check("loss_valid", loss_valid, m_lv);
    check("loss_out", loss_out, m_loss);
`ifdef LOSS_PARENT_OVF_FLAG_EN
    if (m_lv) check("overflow_out", overflow_out, m_ovf);
`endif
    if (loss_valid === 1'b1) begin
      got_loss = loss_out;
      pulses++;
    end
    valid_in = v; H_in = h; Y_in = y; batch_size_in = n; inv_batch_size_in = inv;
    acc_ok = v && m_ready;
    m_lv = 1'b0;
    if (m_drain > 0) begin
      if (m_drain == 1) begin
        q      = scale_model(m_acc, inv, sat);
        m_loss = q[15:0];
        m_lv   = 1'b1;
        m_ovf  = m_acc_sat || sat;
      end
      m_drain--;
    end
    if (acc_ok) begin
      if (!m_in_batch) begin
        m_in_batch = 1'b1; m_acc = 0; m_acc_sat = 1'b0;
        m_rem = (n == 0) ? 1 : int'(n);
      end
      d = longint'($signed(h)) - longint'($signed(y));
      m_acc += d * d;
      if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_acc_sat = 1'b1; end
      m_rem--;
      if (m_rem == 0) begin m_in_batch = 1'b0; m_drain = 3; end
    end
    m_ready = (m_drain == 0);
    m_busy  = m_in_batch || (m_drain > 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_ready", ready_out, 1'b1);
    check("rst_busy", busy_out, 1'b0);
    check("rst_loss", loss_out, 16'h0000);
    check("rst_lv", loss_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int k, input logic [15:0] inv);
    for (int i = 0; i < k; i++) cyc(1'b0, 16'h0000, 16'h0000, 16'd1, inv);
  endtask

  initial begin
    logic [15:0] rh, ry, rn, ri;
    logic        rv;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Four back-to-back unit differences, scaled by 1/4.
    pulses = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0100, 16'h0000, 16'd4, 16'h0040);
    idle(6, 16'h0040);
    check("tp1_loss", got_loss, 16'h0100);
    check("tp1_pulses", pulses, 1);

    // Gap of three idle cycles inside the batch.
    pulses = 0;
    cyc(1'b1, 16'h0200, 16'h0100, 16'd2, 16'h0080);
    idle(3, 16'h0080);
    cyc(1'b1, 16'h0300, 16'h0300, 16'd2, 16'h0080);
    idle(6, 16'h0080);
    check("tp2_loss", got_loss, 16'h0080);
    check("tp2_pulses", pulses, 1);

    // Largest possible difference saturates the scaled result.
    cyc(1'b1, 16'h7FFF, 16'h8000, 16'd1, 16'h0100);
    idle(6, 16'h0100);
    check("tp3_loss", got_loss, 16'h7FFF);

    // Zero batch size behaves as one.
    cyc(1'b1, 16'h0180, 16'h0000, 16'd0, 16'h0100);
    idle(6, 16'h0100);
    check("tp4_loss", got_loss, 16'h0240);

    // Abort a batch half-way, then run a clean one.
    pulses = 0;
    cyc(1'b1, 16'h0100, 16'h0000, 16'd4, 16'h0040);
    cyc(1'b1, 16'h0100, 16'h0000, 16'd4, 16'h0040);
    do_reset();
    idle(6, 16'h0040);
    check("tp5_no_pulse", pulses, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0000, 16'hFF00, 16'd4, 16'h0040);
    idle(6, 16'h0040);
    check("tp5_loss", got_loss, 16'h0100);
    check("tp5_pulses", pulses, 1);

    // valid_in held through DRAIN: those samples are dropped, next batch starts at the pulse.
    pulses = 0;
    cyc(1'b1, 16'h0100, 16'h0000, 16'd2, 16'h0080);
    cyc(1'b1, 16'h0100, 16'h0000, 16'd2, 16'h0080);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h7FFF, 16'h8000, 16'd2, 16'h0080);
    cyc(1'b1, 16'h0080, 16'h0000, 16'd2, 16'h0080);
    check("tp6_first_loss", got_loss, 16'h0100);
    cyc(1'b1, 16'h0080, 16'h0000, 16'd2, 16'h0080);
    idle(6, 16'h0080);
    check("tp6_second_loss", got_loss, 16'h0040);
    check("tp6_pulses", pulses, 2);

    // Random traffic with random gaps, sizes and per-cycle 1/N values.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rh = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        rh = 16'($signed(rh) >>> 6);
        ry = 16'($signed(ry) >>> 6);
      end
      rn = 16'($urandom_range(0, 6));
      ri = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ri = 16'(ri >> 8);
      cyc(rv, rh, ry, rn, ri);
    end
    idle(8, 16'h0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
